// File: rtl/jtag_pkg.sv
// Shared TAP definitions: controller state enum, instruction codes,
// DR selector and the IEEE 1149.1 next-state function.
package jtag_pkg;

  // Sixteen TAP controller states
  typedef enum logic [3:0] {
    ST_TLR      = 4'h0,
    ST_RTI      = 4'h1,
    ST_SEL_DR   = 4'h2,
    ST_CAP_DR   = 4'h3,
    ST_SHIFT_DR = 4'h4,
    ST_EXIT1_DR = 4'h5,
    ST_PAUSE_DR = 4'h6,
    ST_EXIT2_DR = 4'h7,
    ST_UPD_DR   = 4'h8,
    ST_SEL_IR   = 4'h9,
    ST_CAP_IR   = 4'hA,
    ST_SHIFT_IR = 4'hB,
    ST_EXIT1_IR = 4'hC,
    ST_PAUSE_IR = 4'hD,
    ST_EXIT2_IR = 4'hE,
    ST_UPD_IR   = 4'hF
  } tap_state_t;

  // Instruction codes; BYPASS is -1 so a cast to IR_LEN gives all ones
  localparam int INS_BYPASS = -1;
  localparam int INS_IDCODE = 1;
  localparam int INS_USER   = 2;

  // Data register currently selected by the instruction
  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_t;

  // Standard TMS-driven transition table
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = ST_TLR;
    case (s)
      ST_TLR:      n = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      n = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   n = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   n = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: n = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: n = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: n = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: n = tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   n = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   n = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   n = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: n = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: n = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: n = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: n = tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   n = tms ? ST_SEL_DR   : ST_RTI;
      default:     n = ST_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_if.sv
// JTAG pin bundle. The host (master) drives tck/tms/tdi; the TAP (slave)
// drives tdo/tdo_en.
interface jtag_tap_if;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_en;

  modport master (output tck, output tms, output tdi, input tdo, input tdo_en);
  modport slave  (input tck, input tms, input tdi, output tdo, output tdo_en);
endinterface

// File: rtl/jtag_sync.sv
// Two-flop synchronizer for an asynchronous clock-like input, followed by a
// history flop so rising and falling edges of the synced value can be seen.
module jtag_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, prev_q;

  // Synchronizer chain plus one-cycle history of the synced value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/jtag_tap.sv
// Oversampled IEEE 1149.1 TAP controller with BYPASS, USER and optional
// IDCODE data registers. All JTAG pins are sampled in the clk domain.
// Build option: define JTAG_TAP_IDCODE_EN to include the IDCODE register and
// make IDCODE the reset instruction (otherwise BYPASS).
// IR_LEN must be at least 2 so the USER code fits.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int          IR_LEN       = 4,
  parameter int          USER_LEN     = 8,
  parameter logic [31:0] IDCODE_VALUE = 32'h1234_5001
) (
  input  logic                clk,
  input  logic                rst,
  jtag_tap_if.slave           jtag,
  output logic [IR_LEN-1:0]   ir,
  input  logic [USER_LEN-1:0] user_capture,
  output logic [USER_LEN-1:0] user_data,
  output logic                user_update
);

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] RST_INS = IR_LEN'(INS_IDCODE);
`else
  localparam logic [IR_LEN-1:0] RST_INS = IR_LEN'(INS_BYPASS);
`endif

  // IDCODE bit 0 is the mandatory marker bit
  if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_chk
    $error("jtag_tap: IDCODE_VALUE bit 0 must be 1");
  end

  logic tck_rise, tck_fall;
  logic tms_s1_q, tms_s2_q, tdi_s1_q, tdi_s2_q;

  jtag_sync u_tck_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (jtag.tck),
    .rise (tck_rise),
    .fall (tck_fall)
  );

  // Plain two-flop synchronizers for tms and tdi (same latency as tck path)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tms_s1_q <= 1'b0;
      tms_s2_q <= 1'b0;
      tdi_s1_q <= 1'b0;
      tdi_s2_q <= 1'b0;
    end else begin
      tms_s1_q <= jtag.tms;
      tms_s2_q <= tms_s1_q;
      tdi_s1_q <= jtag.tdi;
      tdi_s2_q <= tdi_s1_q;
    end
  end

  tap_state_t          state_q, state_d;
  logic [IR_LEN-1:0]   ir_q, ir_d;
  logic [IR_LEN-1:0]   ir_sr_q, ir_sr_d;
  logic                bypass_q, bypass_d;
  logic [USER_LEN-1:0] user_sr_q, user_sr_d;
  logic [USER_LEN-1:0] user_data_q, user_data_d;
  logic                user_update_q, user_update_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                tms_smp_q, tms_smp_d;
  logic                tdi_smp_q, tdi_smp_d;
  logic                adv_q, adv_d;
`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0]         idcode_sr_q, idcode_sr_d;
`endif

  dr_sel_t dr_sel;
  logic    dr_lsb;
  logic    in_shift;

  // Decode the current instruction into a DR select; unknown codes -> BYPASS
  always_comb begin
    dr_sel = DR_BYPASS;
    dr_lsb = bypass_q;
    if (ir_q == IR_LEN'(INS_USER)) begin
      dr_sel = DR_USER;
      dr_lsb = user_sr_q[0];
    end
`ifdef JTAG_TAP_IDCODE_EN
    if (ir_q == IR_LEN'(INS_IDCODE)) begin
      dr_sel = DR_IDCODE;
      dr_lsb = idcode_sr_q[0];
    end
`endif
  end

  assign in_shift = (state_q == ST_SHIFT_DR) || (state_q == ST_SHIFT_IR);

  // TAP actions: sample pins on tck rise, act one clk later, drive tdo on fall
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    ir_sr_d       = ir_sr_q;
    bypass_d      = bypass_q;
    user_sr_d     = user_sr_q;
    user_data_d   = user_data_q;
    user_update_d = 1'b0;
    tdo_d         = tdo_q;
    tdo_en_d      = tdo_en_q;
    tms_smp_d     = tms_smp_q;
    tdi_smp_d     = tdi_smp_q;
    adv_d         = tck_rise;
`ifdef JTAG_TAP_IDCODE_EN
    idcode_sr_d   = idcode_sr_q;
`endif

    if (tck_rise) begin
      tms_smp_d = tms_s2_q;
      tdi_smp_d = tdi_s2_q;
    end

    if (state_q == ST_TLR) ir_d = RST_INS;

    if (adv_q) begin
      state_d = tap_next(state_q, tms_smp_q);
      case (state_q)
        ST_CAP_IR:   ir_sr_d = IR_LEN'(1);
        ST_SHIFT_IR: ir_sr_d = {tdi_smp_q, ir_sr_q[IR_LEN-1:1]};
        ST_CAP_DR: begin
          case (dr_sel)
            DR_USER:   user_sr_d   = user_capture;
`ifdef JTAG_TAP_IDCODE_EN
            DR_IDCODE: idcode_sr_d = IDCODE_VALUE;
`endif
            default:   bypass_d    = 1'b0;
          endcase
        end
        ST_SHIFT_DR: begin
          case (dr_sel)
            DR_USER:   user_sr_d   = {tdi_smp_q, user_sr_q[USER_LEN-1:1]};
`ifdef JTAG_TAP_IDCODE_EN
            DR_IDCODE: idcode_sr_d = {tdi_smp_q, idcode_sr_q[31:1]};
`endif
            default:   bypass_d    = tdi_smp_q;
          endcase
        end
        default: ;
      endcase

      // Update is taken on entry, so the final shifted value is already in place
      if (state_d == ST_UPD_IR) ir_d = ir_sr_q;
      if ((state_d == ST_UPD_DR) && (dr_sel == DR_USER)) begin
        user_data_d   = user_sr_q;
        user_update_d = 1'b1;
      end
    end

    if (tck_fall) begin
      tdo_en_d = in_shift;
      if (state_q == ST_SHIFT_IR)      tdo_d = ir_sr_q[0];
      else if (state_q == ST_SHIFT_DR) tdo_d = dr_lsb;
      else                             tdo_d = 1'b0;
    end
  end

  // State and register flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_TLR;
      ir_q          <= RST_INS;
      ir_sr_q       <= '0;
      bypass_q      <= 1'b0;
      user_sr_q     <= '0;
      user_data_q   <= '0;
      user_update_q <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_en_q      <= 1'b0;
      tms_smp_q     <= 1'b0;
      tdi_smp_q     <= 1'b0;
      adv_q         <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
      idcode_sr_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_sr_q       <= ir_sr_d;
      bypass_q      <= bypass_d;
      user_sr_q     <= user_sr_d;
      user_data_q   <= user_data_d;
      user_update_q <= user_update_d;
      tdo_q         <= tdo_d;
      tdo_en_q      <= tdo_en_d;
      tms_smp_q     <= tms_smp_d;
      tdi_smp_q     <= tdi_smp_d;
      adv_q         <= adv_d;
`ifdef JTAG_TAP_IDCODE_EN
      idcode_sr_q   <= idcode_sr_d;
`endif
    end
  end

  assign jtag.tdo     = tdo_q;
  assign jtag.tdo_en  = tdo_en_q;
  assign ir           = ir_q;
  assign user_data    = user_data_q;
  assign user_update  = user_update_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Bench for jtag_tap: drives JTAG cycles through the pin interface and
// compares against a table-driven TAP model. Honours JTAG_TAP_IDCODE_EN.
module tb_jtag_tap;

  localparam int IR_LEN   = 4;
  localparam int USER_LEN = 8;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] RST_INS = 4'h1;
  localparam bit IDEN = 1'b1;
`else
  localparam logic [IR_LEN-1:0] RST_INS = 4'hF;
  localparam bit IDEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IR_LEN-1:0]   ir;
  logic [USER_LEN-1:0] user_capture = '0;
  logic [USER_LEN-1:0] user_data;
  logic                user_update;

  jtag_tap_if jif();

  jtag_tap #(.IR_LEN(IR_LEN), .USER_LEN(USER_LEN), .IDCODE_VALUE(32'h1234_5001)) dut (
    .clk          (clk),
    .rst          (rst),
    .jtag         (jif),
    .ir           (ir),
    .user_capture (user_capture),
    .user_data    (user_data),
    .user_update  (user_update)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0;

  always @(posedge clk) if (user_update) upd_cnt <= upd_cnt + 1;

  // ---------------- reference model ----------------
  // states: 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR 6 PauDR 7 Ex2DR 8 UpdDR
  //         9 SelIR 10 CapIR 11 ShIR 12 Ex1IR 13 PauIR 14 Ex2IR 15 UpdIR
  int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int                  m_st;
  logic [IR_LEN-1:0]   m_ir;
  logic [63:0]         m_sr;
  int                  m_len;
  logic [USER_LEN-1:0] m_user;
  int                  m_upd = 0;

  logic [127:0] hist_got, hist_exp;   // {tdo,tdo_en} per cycle
  logic [63:0]  sh_got, sh_exp;       // bits emitted while shifting
  int           sh_n;

  task automatic m_reset();
    m_st = 0; m_ir = RST_INS; m_sr = '0; m_len = 1; m_user = '0;
  endtask

  task automatic m_step(input logic tms_v, input logic tdi_v);
    int nst;
    nst = tms_v ? nx1[m_st] : nx0[m_st];
    if (m_st == 3) begin
      if (m_ir == 4'd2)              begin m_len = USER_LEN; m_sr = 64'(user_capture); end
      else if (IDEN && m_ir == 4'd1) begin m_len = 32; m_sr = 64'h1234_5001; end
      else                           begin m_len = 1; m_sr = '0; end
    end else if (m_st == 10) begin
      m_len = IR_LEN; m_sr = 64'd1;
    end else if (m_st == 4 || m_st == 11) begin
      m_sr = m_sr >> 1;
      m_sr[m_len-1] = tdi_v;
    end
    if (nst == 15) m_ir = m_sr[IR_LEN-1:0];
    if (nst == 8 && m_ir == 4'd2) begin m_user = m_sr[USER_LEN-1:0]; m_upd++; end
    if (nst == 0) m_ir = RST_INS;
    m_st = nst;
  endtask

  // One full tck period; tdo is sampled just before the rising edge
  task automatic cyc(input logic tms_v, input logic tdi_v);
    logic ex_tdo, ex_en;
    jif.tms = tms_v; jif.tdi = tdi_v;
    repeat (6) @(negedge clk);
    ex_en  = (m_st == 4 || m_st == 11);
    ex_tdo = ex_en ? m_sr[0] : 1'b0;
    hist_got = {hist_got[125:0], jif.tdo, jif.tdo_en};
    hist_exp = {hist_exp[125:0], ex_tdo, ex_en};
    if (ex_en && sh_n < 64) begin
      sh_got[sh_n] = jif.tdo; sh_exp[sh_n] = ex_tdo; sh_n++;
    end
    jif.tck = 1'b1;
    m_step(tms_v, tdi_v);
    repeat (8) @(negedge clk);
    jif.tck = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  // Full scan from Run-Test/Idle back to Run-Test/Idle
  task automatic scan(input bit is_ir, input int n, input logic [63:0] din);
    sh_n = 0; sh_got = '0; sh_exp = '0;
    cyc(1'b1, 1'b0);
    if (is_ir) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < n; i++) cyc(i == n - 1, din[i]);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    settle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; jif.tck = 1'b0; jif.tms = 1'b0; jif.tdi = 1'b0;
    hist_got = '0; hist_exp = '0;
    repeat (4) @(negedge clk);
    m_reset();
    total++; if (ir !== m_ir) begin bad++; $display("FAIL reset_ir got=%h want=%h", ir, m_ir); end
    total++; if (jif.tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b want=0", jif.tdo); end
    total++; if (jif.tdo_en !== 1'b0) begin bad++; $display("FAIL reset_tdo_en got=%b want=0", jif.tdo_en); end
    total++; if (user_data !== '0) begin bad++; $display("FAIL reset_user_data got=%h want=0", user_data); end
    total++; if (user_update !== 1'b0) begin bad++; $display("FAIL reset_user_update got=%b want=0", user_update); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_idcode();
    logic [63:0] din;
    din = {$urandom, $urandom};
    hist_got = '0; hist_exp = '0;
    cyc(1'b0, 1'b0);
    scan(1'b0, 32, din);
    total++; if (sh_got[31:0] !== sh_exp[31:0]) begin bad++; $display("FAIL idcode_model got=%h want=%h", sh_got[31:0], sh_exp[31:0]); end
`ifdef JTAG_TAP_IDCODE_EN
    total++; if (sh_got[31:0] !== 32'h1234_5001) begin bad++; $display("FAIL idcode_value got=%h want=12345001", sh_got[31:0]); end
`else
    total++; if (sh_got[31:0] !== {din[30:0], 1'b0}) begin bad++; $display("FAIL bypass_default got=%h want=%h", sh_got[31:0], {din[30:0], 1'b0}); end
`endif
    total++; if (hist_got !== hist_exp) begin bad++; $display("FAIL idcode_pins got=%h want=%h", hist_got, hist_exp); end
    total++; if (ir !== RST_INS) begin bad++; $display("FAIL idcode_ir got=%h want=%h", ir, RST_INS); end
  endtask

  task automatic test_ir_bypass();
    hist_got = '0; hist_exp = '0;
    scan(1'b1, 4, 64'hF);
    total++; if (sh_got[3:0] !== 4'b0001) begin bad++; $display("FAIL ir_capture got=%b want=0001", sh_got[3:0]); end
    total++; if (ir !== 4'hF) begin bad++; $display("FAIL ir_load got=%h want=f", ir); end
    scan(1'b0, 3, 64'b101);
    total++; if (sh_got[2:0] !== 3'b010) begin bad++; $display("FAIL bypass_delay got=%b want=010", sh_got[2:0]); end
    total++; if (hist_got !== hist_exp) begin bad++; $display("FAIL bypass_pins got=%h want=%h", hist_got, hist_exp); end
  endtask

  task automatic test_user();
    logic [7:0] uc, d;
    int u0;
    scan(1'b1, 4, 64'd2);
    total++; if (ir !== 4'd2) begin bad++; $display("FAIL user_ir got=%h want=2", ir); end
    for (int k = 0; k < 3; k++) begin
      uc = (k == 0) ? 8'h3C : 8'($urandom);
      d  = (k == 0) ? 8'hA5 : 8'($urandom);
      user_capture = uc;
      u0 = upd_cnt;
      scan(1'b0, 8, 64'(d));
      total++; if (sh_got[7:0] !== uc) begin bad++; $display("FAIL user_tdo[%0d] got=%h want=%h", k, sh_got[7:0], uc); end
      total++; if (user_data !== d) begin bad++; $display("FAIL user_data[%0d] got=%h want=%h", k, user_data, d); end
      total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL user_update[%0d] got=%0d want=1", k, upd_cnt - u0); end
    end
  endtask

  task automatic test_tlr_from_shift();
    int u0;
    scan(1'b1, 4, 64'h7);
    u0 = upd_cnt;
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    settle();
    total++; if (ir !== RST_INS) begin bad++; $display("FAIL tlr_ir got=%h want=%h", ir, RST_INS); end
    total++; if (upd_cnt !== u0) begin bad++; $display("FAIL tlr_no_update got=%0d want=%0d", upd_cnt, u0); end
    total++; if (jif.tdo_en !== 1'b0) begin bad++; $display("FAIL tlr_tdo_en got=%b want=0", jif.tdo_en); end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_pause();
    logic [7:0] uc, d;
    int u0;
    scan(1'b1, 4, 64'd2);
    uc = 8'($urandom); d = 8'($urandom);
    user_capture = uc;
    u0 = upd_cnt;
    sh_n = 0; sh_got = '0; sh_exp = '0;
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(i == 3, d[i]);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'($urandom));
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 4; i < 8; i++) cyc(i == 7, d[i]);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    settle();
    total++; if (sh_n !== 8) begin bad++; $display("FAIL pause_bits got=%0d want=8", sh_n); end
    total++; if (sh_got[7:0] !== uc) begin bad++; $display("FAIL pause_tdo got=%h want=%h", sh_got[7:0], uc); end
    total++; if (user_data !== d) begin bad++; $display("FAIL pause_data got=%h want=%h", user_data, d); end
    total++; if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL pause_update got=%0d want=1", upd_cnt - u0); end
  endtask

  task automatic test_random_walk();
    int u0, mu0;
    user_capture = 8'($urandom);
    hist_got = '0; hist_exp = '0;
    u0 = upd_cnt; mu0 = m_upd;
    for (int i = 0; i < 60; i++) cyc($urandom_range(0, 2) == 0, 1'($urandom));
    settle();
    total++; if (hist_got !== hist_exp) begin bad++; $display("FAIL walk_pins got=%h want=%h", hist_got, hist_exp); end
    total++; if (ir !== m_ir) begin bad++; $display("FAIL walk_ir got=%h want=%h", ir, m_ir); end
    total++; if (user_data !== m_user) begin bad++; $display("FAIL walk_data got=%h want=%h", user_data, m_user); end
    total++; if (upd_cnt - u0 !== m_upd - mu0) begin bad++; $display("FAIL walk_updates got=%0d want=%0d", upd_cnt - u0, m_upd - mu0); end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
    settle();
    total++; if (ir !== RST_INS) begin bad++; $display("FAIL walk_tlr_ir got=%h want=%h", ir, RST_INS); end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    int u0;
    scan(1'b1, 4, 64'd2);
    user_capture = 8'h81;
    scan(1'b0, 8, 64'h5A);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b0); cyc(1'b0, 1'b1);
    settle();
    total++; if (jif.tdo_en !== 1'b1) begin bad++; $display("FAIL midshift_en got=%b want=1", jif.tdo_en); end
    u0 = upd_cnt;
    #2 rst = 1'b1;
    #1;
    total++; if (jif.tdo !== 1'b0) begin bad++; $display("FAIL arst_tdo got=%b want=0", jif.tdo); end
    total++; if (jif.tdo_en !== 1'b0) begin bad++; $display("FAIL arst_tdo_en got=%b want=0", jif.tdo_en); end
    total++; if (ir !== RST_INS) begin bad++; $display("FAIL arst_ir got=%h want=%h", ir, RST_INS); end
    total++; if (user_data !== '0) begin bad++; $display("FAIL arst_data got=%h want=0", user_data); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    total++; if (upd_cnt !== u0) begin bad++; $display("FAIL arst_no_update got=%0d want=%0d", upd_cnt, u0); end
    cyc(1'b0, 1'b0);
    scan(1'b1, 4, 64'd2);
    total++; if (ir !== 4'd2) begin bad++; $display("FAIL post_rst_ir got=%h want=2", ir); end
  endtask

  initial begin
    jif.tck = 1'b0; jif.tms = 1'b0; jif.tdi = 1'b0;
    sh_n = 0; sh_got = '0; sh_exp = '0;
    m_reset();
    test_reset();
    test_idcode();
    test_ir_bypass();
    test_user();
    test_tlr_from_shift();
    test_pause();
    test_random_walk();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
